// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int WAIT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_RD_DONE  = 3'd5
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DBG = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// whichever side did not win last time.
module rr_pick2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  // Pick the winner from the current request pair and the previous owner.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ_CPU;
    if (req == 2'b11) gnt_id = ~last_grant;
    else if (req[1])  gnt_id = REQ_DBG;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM port between the CPU path (port 0) and the
// debug/program-loader path (port 1), with programmable strobe wait states.
// Optional build macro SRAM_ARB_STATS_EN adds saturating grant/contention counters.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | no transfer; arbitrate and latch address/data on a request
// ST_RD       | OE_N low for WAIT_CYCLES+1 cycles, data captured on the last
// ST_RD_DONE  | owner's ack pulse, rdata valid
// ST_WR_SETUP | address/data settle with WE_N high
// ST_WR_PULSE | WE_N low for WAIT_CYCLES+1 cycles
// ST_WR_HOLD  | WE_N high, address/data held, owner's ack pulse
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
)(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              grant_id,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
`ifdef SRAM_ARB_STATS_EN
  output logic [15:0]       cpu_grants,
  output logic [15:0]       dbg_grants,
  output logic [15:0]       contention,
`endif
  output logic              OE_N,
  output logic              WE_N
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  req_id_t           last_grant;
  logic              gnt_valid;
  req_id_t           gnt_id;
  logic              sel_we;

  rr_pick2 u_pick (
    .req        ({dbg_req, cpu_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign sel_we = (gnt_id == REQ_DBG) ? dbg_we : cpu_we;
  assign busy   = (state != ST_IDLE);

  // Main sequencer: arbitration, strobe timing, address/data latching, acks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      last_grant   <= REQ_DBG;
      grant_id     <= REQ_CPU;
      ADDR         <= '0;
      Data_to_SRAM <= '0;
      rdata        <= '0;
      OE_N         <= 1'b1;
      WE_N         <= 1'b1;
      cpu_ack      <= 1'b0;
      dbg_ack      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_id     <= gnt_id;
            last_grant   <= gnt_id;
            ADDR         <= (gnt_id == REQ_DBG) ? dbg_addr  : cpu_addr;
            Data_to_SRAM <= (gnt_id == REQ_DBG) ? dbg_wdata : cpu_wdata;
            wait_cnt     <= WAIT_INIT;
            if (sel_we) begin
              state <= ST_WR_SETUP;
            end else begin
              state <= ST_RD;
              OE_N  <= 1'b0;
            end
          end
        end
        ST_RD: begin
          if (wait_cnt == '0) begin
            rdata   <= Data_from_SRAM;
            OE_N    <= 1'b1;
            state   <= ST_RD_DONE;
            cpu_ack <= (grant_id == REQ_CPU);
            dbg_ack <= (grant_id == REQ_DBG);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RD_DONE: state <= ST_IDLE;
        ST_WR_SETUP: begin
          WE_N     <= 1'b0;
          wait_cnt <= WAIT_INIT;
          state    <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (wait_cnt == '0) begin
            WE_N    <= 1'b1;
            state   <= ST_WR_HOLD;
            cpu_ack <= (grant_id == REQ_CPU);
            dbg_ack <= (grant_id == REQ_DBG);
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_WR_HOLD: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          OE_N  <= 1'b1;
          WE_N  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  // Saturating usage counters, bumped on each grant taken in IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_grants <= '0;
      dbg_grants <= '0;
      contention <= '0;
    end else if (state == ST_IDLE && gnt_valid) begin
      if (gnt_id == REQ_CPU && cpu_grants != 16'hFFFF) cpu_grants <= cpu_grants + 16'd1;
      if (gnt_id == REQ_DBG && dbg_grants != 16'hFFFF) dbg_grants <= dbg_grants + 16'd1;
      if (cpu_req && dbg_req && contention != 16'hFFFF) contention <= contention + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter (WAIT_CYCLES=2 and 0 instances).
module tb_sram_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, Data_from_SRAM;
  logic        cpu_ack, dbg_ack, busy, grant_id, OE_N, WE_N;
  logic [15:0] rdata, ADDR, Data_to_SRAM;

  logic        cpu_req_z, cpu_we_z, dbg_req_z, dbg_we_z;
  logic [15:0] cpu_addr_z, cpu_wdata_z, dbg_addr_z, dbg_wdata_z, Data_from_SRAM_z;
  logic        cpu_ack_z, dbg_ack_z, busy_z, grant_id_z, OE_N_z, WE_N_z;
  logic [15:0] rdata_z, ADDR_z, Data_to_SRAM_z;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] cpu_grants, dbg_grants, contention;
  logic [15:0] cpu_grants_z, dbg_grants_z, contention_z;
`endif

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
    .rdata(rdata), .busy(busy), .grant_id(grant_id), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM),
`ifdef SRAM_ARB_STATS_EN
    .cpu_grants(cpu_grants), .dbg_grants(dbg_grants), .contention(contention),
`endif
    .OE_N(OE_N), .WE_N(WE_N)
  );

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) u_dut_z (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req_z), .cpu_we(cpu_we_z), .cpu_addr(cpu_addr_z), .cpu_wdata(cpu_wdata_z), .cpu_ack(cpu_ack_z),
    .dbg_req(dbg_req_z), .dbg_we(dbg_we_z), .dbg_addr(dbg_addr_z), .dbg_wdata(dbg_wdata_z), .dbg_ack(dbg_ack_z),
    .rdata(rdata_z), .busy(busy_z), .grant_id(grant_id_z), .ADDR(ADDR_z), .Data_to_SRAM(Data_to_SRAM_z),
    .Data_from_SRAM(Data_from_SRAM_z),
`ifdef SRAM_ARB_STATS_EN
    .cpu_grants(cpu_grants_z), .dbg_grants(dbg_grants_z), .contention(contention_z),
`endif
    .OE_N(OE_N_z), .WE_N(WE_N_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, n_cpu, n_dbg, cyc;
    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    Data_from_SRAM = '0;
    cpu_req_z = 0; cpu_we_z = 0; cpu_addr_z = '0; cpu_wdata_z = '0;
    dbg_req_z = 0; dbg_we_z = 0; dbg_addr_z = '0; dbg_wdata_z = '0;
    Data_from_SRAM_z = 16'h5A5A;
    repeat (3) tick();

    // reset values
    chk("rst_oe_n", 32'(OE_N), 32'd1);
    chk("rst_we_n", 32'(WE_N), 32'd1);
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_wdata", 32'(Data_to_SRAM), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_acks", 32'({cpu_ack, dbg_ack}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);

    // 1: CPU read, WAIT_CYCLES=2
    Reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0030; Data_from_SRAM = 16'hBEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t1_oe_n_c%0d", k), 32'(OE_N), (k <= 3) ? 32'd0 : 32'd1);
      chk($sformatf("t1_cpu_ack_c%0d", k), 32'(cpu_ack), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("t1_dbg_ack_c%0d", k), 32'(dbg_ack), 32'd0);
      chk($sformatf("t1_addr_c%0d", k), 32'(ADDR), 32'h0030);
      if (cpu_ack) cpu_req = 0;
    end
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    cpu_req = 0;
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: DBG write
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0100; dbg_wdata = 16'h1234;
    Data_from_SRAM = 16'h0BAD;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("t2_we_n_c%0d", k), 32'(WE_N), (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
      chk($sformatf("t2_oe_n_c%0d", k), 32'(OE_N), 32'd1);
      chk($sformatf("t2_dbg_ack_c%0d", k), 32'(dbg_ack), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("t2_cpu_ack_c%0d", k), 32'(cpu_ack), 32'd0);
      chk($sformatf("t2_addr_c%0d", k), 32'(ADDR), 32'h0100);
      chk($sformatf("t2_data_c%0d", k), 32'(Data_to_SRAM), 32'h1234);
      if (dbg_ack) dbg_req = 0;
    end
    chk("t2_grant_id", 32'(grant_id), 32'd1);
    chk("t2_rdata_held", 32'(rdata), 32'hBEEF);
    dbg_req = 0;

    // 3: both requests from reset, held
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0011;
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0022; dbg_wdata = 16'h00DD;
    n_ack = 0; n_cpu = 0; n_dbg = 0; cyc = 0;
    while (n_ack < 8 && cyc < 200) begin
      tick();
      cyc++;
      if (!OE_N && !WE_N) chk("t3_strobe_overlap", 32'({OE_N, WE_N}), 32'd3);
      if (cpu_ack || dbg_ack) begin
        chk($sformatf("t3_both_ack_%0d", n_ack), 32'(cpu_ack & dbg_ack), 32'd0);
        chk($sformatf("t3_order_%0d", n_ack), cpu_ack ? 32'd0 : 32'd1, 32'(n_ack % 2));
        if (cpu_ack) n_cpu++;
        if (dbg_ack) n_dbg++;
        n_ack++;
      end
    end
    chk("t3_ack_total", 32'(n_ack), 32'd8);
    chk("t3_cpu_acks", 32'(n_cpu), 32'd4);
    chk("t3_dbg_acks", 32'(n_dbg), 32'd4);
    cpu_req = 0; dbg_req = 0;

    // 4: reset during the second WR_PULSE cycle
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0077; cpu_wdata = 16'h9999;
    tick();
    chk("t4_setup_we_n", 32'(WE_N), 32'd1);
    tick();
    chk("t4_pulse1_we_n", 32'(WE_N), 32'd0);
    tick();
    chk("t4_pulse2_we_n", 32'(WE_N), 32'd0);
    chk("t4_pulse2_busy", 32'(busy), 32'd1);
    Reset = 1'b1;
    cpu_req = 0;
    tick();
    chk("t4_rst_we_n", 32'(WE_N), 32'd1);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_ack", 32'({cpu_ack, dbg_ack}), 32'd0);
    chk("t4_rst_addr", 32'(ADDR), 32'd0);
    chk("t4_rst_data", 32'(Data_to_SRAM), 32'd0);
    tick();
    chk("t4_rst_ack2", 32'({cpu_ack, dbg_ack}), 32'd0);
    Reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0055; Data_from_SRAM = 16'hA5A5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t4_rd_ack_c%0d", k), 32'(cpu_ack), (k == 4) ? 32'd1 : 32'd0);
      if (cpu_ack) cpu_req = 0;
    end
    chk("t4_rd_rdata", 32'(rdata), 32'hA5A5);
    cpu_req = 0;
    tick();

    // 5: WAIT_CYCLES=0 back-to-back CPU reads
    cpu_req_z = 1; cpu_we_z = 0; cpu_addr_z = 16'h0042;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("t5_ack_c%0d", k), 32'(cpu_ack_z), (k % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t5_busy_c%0d", k), 32'(busy_z), (k % 3 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t5_oe_n_c%0d", k), 32'(OE_N_z), (k % 3 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("t5_we_n_c%0d", k), 32'(WE_N_z), 32'd1);
    end
    chk("t5_rdata", 32'(rdata_z), 32'h5A5A);
    cpu_req_z = 0;
    tick();

`ifdef SRAM_ARB_STATS_EN
    // 6: statistics after five contended grants
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t6_rst_contention", 32'(contention), 32'd0);
    cpu_req = 1; cpu_we = 0; dbg_req = 1; dbg_we = 0;
    n_ack = 0; cyc = 0;
    while (n_ack < 5 && cyc < 200) begin
      tick();
      cyc++;
      if (cpu_ack || dbg_ack) begin
        n_ack++;
        if (n_ack == 5) begin
          cpu_req = 0; dbg_req = 0;
        end
      end
    end
    cpu_req = 0; dbg_req = 0;
    repeat (2) tick();
    chk("t6_acks", 32'(n_ack), 32'd5);
    chk("t6_contention", 32'(contention), 32'd5);
    chk("t6_grant_sum", 32'(cpu_grants) + 32'(dbg_grants), 32'(n_ack));
    chk("t6_cpu_grants", 32'(cpu_grants), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
